// File: rtl/sap2_bus_arbiter.sv
// sap2_bus_arbiter: round-robin bus owner selection with hold-limit
// preemption and an AND-OR driver mux for the SAP-2 internal bus.
module sap2_bus_arbiter #(
  parameter int NREQ     = 4,
  parameter int W        = 16,
  parameter int MAX_HOLD = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ-1:0]         lock,
  input  logic [NREQ*W-1:0]       din,
  output logic [NREQ-1:0]         gnt,
  output logic [$clog2(NREQ)-1:0] owner,
  output logic [W-1:0]            bus_out,
  output logic                    bus_valid,
  output logic                    preempt
);

  localparam int OW  = $clog2(NREQ);
  localparam int CW  = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
  localparam int LIM = (MAX_HOLD > 0) ? MAX_HOLD - 1 : 0;

  typedef enum logic {
    IDLE,
    GRANT
  } state_t;

  state_t          state_q, state_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [OW-1:0]   own_q, own_d;
  logic [OW-1:0]   last_q, last_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            pre_q, pre_d;

  logic [NREQ-1:0] cand;
  logic            rr_hit;
  logic [OW-1:0]   rr_idx;
  logic            expire;
  logic            rel;
  logic            take;

  // The current owner never competes in its own re-arbitration.
  always_comb begin
    cand = req;
    if (state_q == GRANT) cand[own_q] = 1'b0;
  end

  always_comb begin
    int j;
    j      = 0;
    rr_hit = 1'b0;
    rr_idx = '0;
    for (int k = 1; k <= NREQ; k++) begin
      j = (int'(last_q) + k) % NREQ;
      if (!rr_hit && cand[j]) begin
        rr_hit = 1'b1;
        rr_idx = OW'(j);
      end
    end
  end

  assign expire = (MAX_HOLD > 0)
               && (int'(cnt_q) >= LIM)
               && !lock[own_q];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      own_q   <= '0;
      last_q  <= OW'(NREQ - 1);
      cnt_q   <= '0;
      pre_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      own_q   <= own_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      pre_q   <= pre_d;
    end
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    own_d   = own_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    pre_d   = 1'b0;
    rel     = 1'b0;
    take    = 1'b0;
    unique case (state_q)
      IDLE: begin
        take = rr_hit;
      end
      GRANT: begin
        rel   = !req[own_q];
        take  = rr_hit && (rel || expire);
        pre_d = rr_hit && !rel && expire;
        if (rel && !rr_hit) begin
          state_d = IDLE;
          gnt_d   = '0;
        end else if (!take && int'(cnt_q) < MAX_HOLD) begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase
    if (take) begin
      state_d = GRANT;
      gnt_d   = NREQ'(1) << rr_idx;
      own_d   = rr_idx;
      last_d  = rr_idx;
      cnt_d   = '0;
    end
  end

  always_comb begin
    bus_out = '0;
    for (int i = 0; i < NREQ; i++)
      bus_out = bus_out | (din[i*W +: W] & {W{gnt_q[i]}});
  end

  assign gnt       = gnt_q;
  assign owner     = own_q;
  assign bus_valid = |gnt_q;
  assign preempt   = pre_q;

endmodule

// File: tb/tb_sap2_bus_arbiter.sv
// tb_sap2_bus_arbiter: vector table, corner sequences and a random
// run against an integer-level round-robin reference model.
module tb_sap2_bus_arbiter;

  localparam int NREQ     = 4;
  localparam int W        = 16;
  localparam int MAX_HOLD = 8;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NREQ-1:0]   req;
  logic [NREQ-1:0]   lock;
  logic [NREQ*W-1:0] din;
  logic [NREQ-1:0]   gnt;
  logic [1:0]        owner;
  logic [W-1:0]      bus_out;
  logic              bus_valid;
  logic              preempt;

  int checks = 0;
  int errors = 0;

  sap2_bus_arbiter #(
    .NREQ(NREQ),
    .W(W),
    .MAX_HOLD(MAX_HOLD)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .req(req),
    .lock(lock),
    .din(din),
    .gnt(gnt),
    .owner(owner),
    .bus_out(bus_out),
    .bus_valid(bus_valid),
    .preempt(preempt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] own;
  } vec_t;

  vec_t tbl[10];

  // Reference: owner as an int (-1 = idle), held = edges since grant.
  bit model_on = 1'b0;
  int m_owner;
  int m_last;
  int m_held;
  bit m_pre;

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic int pick(input logic [3:0] r,
                              input int from,
                              input int excl);
    for (int k = 1; k <= NREQ; k++) begin
      int u = (from + k) % NREQ;
      if (u != excl && r[u]) return u;
    end
    return -1;
  endfunction

  task automatic model_step();
    int n;
    m_pre = 1'b0;
    if (m_owner < 0) begin
      n = pick(req, m_last, -1);
      if (n >= 0) begin
        m_owner = n;
        m_last  = n;
        m_held  = 0;
      end
    end else if (!req[m_owner]) begin
      n = pick(req, m_last, m_owner);
      m_owner = n;
      if (n >= 0) begin
        m_last = n;
        m_held = 0;
      end
    end else begin
      n = pick(req, m_last, m_owner);
      if (m_held + 1 >= MAX_HOLD && !lock[m_owner] && n >= 0) begin
        m_owner = n;
        m_last  = n;
        m_held  = 0;
        m_pre   = 1'b1;
      end else begin
        m_held++;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (model_on) model_step();
    #1;
  endtask

  task automatic check_model();
    logic [3:0]   eg;
    logic [W-1:0] eb;
    eg = '0;
    eb = '0;
    if (m_owner >= 0) begin
      eg[m_owner] = 1'b1;
      eb = din[m_owner*W +: W];
      check("rnd owner", owner, m_owner);
    end
    check("rnd gnt", gnt, eg);
    check("rnd preempt", preempt, m_pre);
    check("rnd bus_valid", bus_valid, m_owner >= 0);
    check("rnd bus_out", bus_out, eb);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{4'b1111, 4'b0001, 2'd0};
    tbl[1] = '{4'b1110, 4'b0010, 2'd1};
    tbl[2] = '{4'b1100, 4'b0100, 2'd2};
    tbl[3] = '{4'b1000, 4'b1000, 2'd3};
    tbl[4] = '{4'b0000, 4'b0000, 2'd0};
    tbl[5] = '{4'b0100, 4'b0100, 2'd2};
    tbl[6] = '{4'b0001, 4'b0001, 2'd0};
    tbl[7] = '{4'b0101, 4'b0001, 2'd0};
    tbl[8] = '{4'b0100, 4'b0100, 2'd2};
    tbl[9] = '{4'b0000, 4'b0000, 2'd0};

    rst_n = 1'b0;
    req   = '0;
    lock  = '0;
    din   = {16'hFFFF, 16'h1234, 16'h5A5A, 16'hA5A5};
    repeat (2) @(posedge clk);
    #1;
    check("reset gnt", gnt, 4'b0000);
    check("reset owner", owner, 2'd0);
    check("reset preempt", preempt, 1'b0);
    check("reset bus_valid", bus_valid, 1'b0);
    check("reset bus_out", bus_out, 16'h0000);
    rst_n = 1'b1;

    // Rotation without idle cycles, then wrap-around.
    for (int i = 0; i < 10; i++) begin
      req = tbl[i].req;
      tick();
      check($sformatf("vec%0d gnt", i), gnt, tbl[i].gnt);
      if (tbl[i].gnt != 4'b0000)
        check($sformatf("vec%0d owner", i), owner, tbl[i].own);
    end

    // Hold limit: preempt exactly 8 edges after grant.
    req = 4'b0010;
    tick();
    check("hold grant", gnt, 4'b0010);
    req = 4'b1010;
    for (int i = 1; i < MAX_HOLD; i++) begin
      tick();
      check($sformatf("hold keep%0d", i), gnt, 4'b0010);
      check($sformatf("hold nopre%0d", i), preempt, 1'b0);
    end
    tick();
    check("hold move", gnt, 4'b1000);
    check("hold pulse", preempt, 1'b1);
    tick();
    check("hold pulse end", preempt, 1'b0);
    check("hold stay", gnt, 4'b1000);
    req = 4'b0000;
    tick();
    check("hold idle", gnt, 4'b0000);

    // Lock defers preemption until it drops.
    req  = 4'b0010;
    lock = 4'b0010;
    tick();
    check("lock grant", gnt, 4'b0010);
    req = 4'b1010;
    for (int i = 0; i < 20; i++) begin
      tick();
      check($sformatf("lock keep%0d", i), gnt, 4'b0010);
      check($sformatf("lock nopre%0d", i), preempt, 1'b0);
    end
    lock = 4'b0000;
    tick();
    check("unlock move", gnt, 4'b1000);
    check("unlock pulse", preempt, 1'b1);
    req = 4'b0000;
    tick();
    check("unlock idle", gnt, 4'b0000);

    // Data mux follows the owner, zero when idle.
    check("mux idle", bus_out, 16'h0000);
    req = 4'b0001;
    tick();
    check("mux own0", bus_out, 16'hA5A5);
    req = 4'b0010;
    tick();
    check("mux own1", bus_out, 16'h5A5A);
    req = 4'b0001;
    tick();
    check("mux back0", bus_out, 16'hA5A5);
    req = 4'b0000;
    tick();
    check("mux idle2", bus_out, 16'h0000);
    check("mux valid", bus_valid, 1'b0);

    // Asynchronous reset in the middle of a grant.
    req = 4'b0001;
    tick();
    check("arst pre gnt", gnt, 4'b0001);
    rst_n = 1'b0;
    #1;
    check("arst gnt", gnt, 4'b0000);
    check("arst bus_out", bus_out, 16'h0000);
    check("arst valid", bus_valid, 1'b0);
    #2;
    rst_n = 1'b1;
    req   = 4'b1010;
    tick();
    check("arst regrant", gnt, 4'b0010);
    req = 4'b0000;
    tick();

    // Random run against the reference model.
    rst_n = 1'b0;
    #1;
    rst_n    = 1'b1;
    m_owner  = -1;
    m_last   = NREQ - 1;
    m_held   = 0;
    m_pre    = 1'b0;
    model_on = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      for (int b = 0; b < NREQ; b++) begin
        if ($urandom_range(0, 5) == 0) req[b] = ~req[b];
        if ($urandom_range(0, 11) == 0) lock[b] = ~lock[b];
      end
      din = {$urandom, $urandom};
      tick();
      check_model();
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
